// File: rtl/inst_rom_ctrl_if.sv
// Fetch/boot-loader bus of the instruction ROM: loader writes program words,
// the fetch stage presents a word address and reads back the instruction.
interface inst_rom_ctrl_if #(
  parameter int AW = 10
);
  // load_valid qualifies load_data for exactly one clock; there is no
  // back-pressure, so every sampled load_valid is consumed or dropped.
  logic          load_start;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_done;
  logic [31:0]   inst_addr;
  logic [31:0]   inst_data;
  logic          ready;
  logic [AW:0]   loaded_cnt;
  logic          load_err;

  modport master (
    output load_start, load_valid, load_data, load_done, inst_addr,
    input  inst_data, ready, loaded_cnt, load_err
  );

  modport slave (
    input  load_start, load_valid, load_data, load_done, inst_addr,
    output inst_data, ready, loaded_cnt, load_err
  );
endinterface

// File: rtl/inst_rom_ctrl.sv
// Instruction memory responder: boot loader fills words, fetch stage reads them.
// A zero word means "no instruction" (empty, wait state or out of range).
module inst_rom_ctrl #(
  parameter int DEPTH    = 1024,
  parameter int AW       = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  inst_rom_ctrl_if.slave bus,
  output logic [1:0]     o_dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t      r_state;
  state_t      w_state_d;
  logic [AW:0] r_loaded_cnt;
  logic [AW:0] w_loaded_cnt_d;
  logic        r_load_err;
  logic        w_load_err_d;
  logic        w_we;

  logic [31:0] r_mem [DEPTH];

  logic [31:0] r_a_q;
  logic        r_aq_v;
  logic [3:0]  r_cnt;
  logic        w_same_addr;
  logic        w_in_range;
  logic        w_hit;

  // load_start outranks everything: a colliding load_valid word is dropped.
  always_comb begin
    w_state_d      = r_state;
    w_loaded_cnt_d = r_loaded_cnt;
    w_load_err_d   = r_load_err;
    w_we           = 1'b0;
    if (bus.load_start) begin
      w_loaded_cnt_d = '0;
      w_load_err_d   = 1'b0;
    end else if (r_state == ST_LOAD && bus.load_valid) begin
      if (r_loaded_cnt == CNT_FULL) begin
        w_load_err_d = 1'b1;
      end else begin
        w_we           = 1'b1;
        w_loaded_cnt_d = r_loaded_cnt + 1'b1;
      end
    end

    case (r_state)
      ST_EMPTY: if (bus.load_start) w_state_d = ST_LOAD;
      ST_LOAD: begin
        if (bus.load_start) begin
          w_state_d = ST_LOAD;
        end else if (bus.load_done) begin
          // Uses the post-write count so a word sharing the done cycle counts.
          w_state_d = (w_loaded_cnt_d != '0) ? ST_RUN : ST_EMPTY;
        end
      end
      ST_RUN:  if (bus.load_start) w_state_d = ST_LOAD;
      default: w_state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_loaded_cnt <= '0;
      r_load_err   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_loaded_cnt <= w_loaded_cnt_d;
      r_load_err   <= w_load_err_d;
    end
  end

  // Contents survive reset and reload; only r_loaded_cnt bounds visibility.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_loaded_cnt[AW-1:0]] <= bus.load_data;
  end

  assign w_same_addr = (bus.inst_addr == r_a_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q  <= '0;
      r_aq_v <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state != ST_RUN) begin
      r_aq_v <= 1'b0;
    end else if (!r_aq_v || !w_same_addr) begin
      r_a_q  <= bus.inst_addr;
      r_aq_v <= 1'b1;
      r_cnt  <= WAIT_INIT;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign w_in_range = (bus.inst_addr[31:AW] == '0) &&
                      ({1'b0, bus.inst_addr[AW-1:0]} < r_loaded_cnt);

  assign w_hit = (WAIT_CYC == 0) ? w_in_range
               : (r_aq_v && w_same_addr && (r_cnt == 4'd0) && w_in_range);

  assign bus.inst_data  = (r_state == ST_RUN && w_hit) ? r_mem[bus.inst_addr[AW-1:0]] : '0;
  assign bus.ready      = (r_state == ST_RUN);
  assign bus.loaded_cnt = r_loaded_cnt;
  assign bus.load_err   = r_load_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Bench for inst_rom_ctrl: three instances (WAIT 1 / DEPTH 4 WAIT 2 / WAIT 0)
// driven by directed vectors; expectations go to a queue checked at negedge.
module tb_inst_rom_ctrl;

  localparam int F_DATA  = 0;
  localparam int F_READY = 1;
  localparam int F_CNT   = 2;
  localparam int F_ERR   = 3;
  localparam int F_STATE = 4;

  logic clk;
  logic rst_n;

  logic        d_start [3];
  logic        d_valid [3];
  logic        d_done  [3];
  logic [31:0] d_data  [3];
  logic [31:0] d_addr  [3];

  logic [31:0] o_data  [3];
  logic        o_ready [3];
  logic [31:0] o_cnt   [3];
  logic        o_err   [3];
  logic [1:0]  o_state [3];

  logic [39:0] exp_q[$];
  logic [31:0] prog_q[$];
  int          n_vec;
  int          n_err;
  string       fname [5] = '{"inst_data", "ready", "loaded_cnt", "load_err", "state"};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  inst_rom_ctrl_if #(.AW(10)) if_a ();
  inst_rom_ctrl_if #(.AW(2))  if_b ();
  inst_rom_ctrl_if #(.AW(4))  if_c ();

  inst_rom_ctrl #(.DEPTH(1024), .AW(10), .WAIT_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .o_dbg_state(o_state[0]));
  inst_rom_ctrl #(.DEPTH(4), .AW(2), .WAIT_CYC(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .o_dbg_state(o_state[1]));
  inst_rom_ctrl #(.DEPTH(16), .AW(4), .WAIT_CYC(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c), .o_dbg_state(o_state[2]));

  assign if_a.load_start = d_start[0];
  assign if_a.load_valid = d_valid[0];
  assign if_a.load_done  = d_done[0];
  assign if_a.load_data  = d_data[0];
  assign if_a.inst_addr  = d_addr[0];
  assign o_data[0]  = if_a.inst_data;
  assign o_ready[0] = if_a.ready;
  assign o_cnt[0]   = 32'(if_a.loaded_cnt);
  assign o_err[0]   = if_a.load_err;

  assign if_b.load_start = d_start[1];
  assign if_b.load_valid = d_valid[1];
  assign if_b.load_done  = d_done[1];
  assign if_b.load_data  = d_data[1];
  assign if_b.inst_addr  = d_addr[1];
  assign o_data[1]  = if_b.inst_data;
  assign o_ready[1] = if_b.ready;
  assign o_cnt[1]   = 32'(if_b.loaded_cnt);
  assign o_err[1]   = if_b.load_err;

  assign if_c.load_start = d_start[2];
  assign if_c.load_valid = d_valid[2];
  assign if_c.load_done  = d_done[2];
  assign if_c.load_data  = d_data[2];
  assign if_c.inst_addr  = d_addr[2];
  assign o_data[2]  = if_c.inst_data;
  assign o_ready[2] = if_c.ready;
  assign o_cnt[2]   = 32'(if_c.loaded_cnt);
  assign o_err[2]   = if_c.load_err;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      d_start[i] = 1'b0;
      d_valid[i] = 1'b0;
      d_done[i]  = 1'b0;
    end
  endtask

  task automatic expect_val(input int d, input int f, input logic [31:0] v);
    exp_q.push_back({4'(d), 4'(f), v});
  endtask

  // Start pulse, one word per cycle from prog_q, then done (or merged with
  // the last word). Returns in the first cycle after the done edge.
  task automatic do_load(input int d, input bit merge);
    int n;
    n = prog_q.size();
    tick();
    d_start[d] = 1'b1;
    tick();
    expect_val(d, F_STATE, 32'd1);
    expect_val(d, F_READY, 32'd0);
    expect_val(d, F_CNT,   32'd0);
    expect_val(d, F_ERR,   32'd0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      d_valid[d] = 1'b1;
      d_data[d]  = prog_q[i];
      if (merge && i == n - 1) d_done[d] = 1'b1;
    end
    if (!merge || n == 0) begin
      if (n > 0) tick();
      d_done[d] = 1'b1;
    end
    tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  function automatic logic [31:0] observe(input int d, input int f);
    case (f)
      F_DATA:  return o_data[d];
      F_READY: return {31'd0, o_ready[d]};
      F_CNT:   return o_cnt[d];
      F_ERR:   return {31'd0, o_err[d]};
      default: return {30'd0, o_state[d]};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [39:0] e;
    logic [31:0] act;
    int d;
    int f;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      d   = int'(e[39:36]);
      f   = int'(e[35:32]);
      act = observe(d, f);
      n_vec++;
      if (act !== e[31:0]) begin
        n_err++;
        $display("FAIL dut%0d %s @%0t: got %h expected %h", d, fname[f], $time, act, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_start[i] = 1'b0;
      d_valid[i] = 1'b0;
      d_done[i]  = 1'b0;
      d_data[i]  = '0;
      d_addr[i]  = '0;
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_val(i, F_STATE, 32'd0);
      expect_val(i, F_READY, 32'd0);
      expect_val(i, F_CNT,   32'd0);
      expect_val(i, F_ERR,   32'd0);
      expect_val(i, F_DATA,  32'd0);
    end
    tick();
    rst_n = 1'b1;

    // Empty ROM: zero word, not ready
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_val(0, F_DATA,  32'd0);
      expect_val(0, F_READY, 32'd0);
    end

    // Three-word load, WAIT_CYC = 1
    prog_q = '{32'h0050_0093, 32'h0010_8113, 32'h0000_006F};
    do_load(0, 1'b0);
    expect_val(0, F_READY, 32'd1);
    expect_val(0, F_CNT,   32'd3);
    expect_val(0, F_STATE, 32'd2);
    expect_val(0, F_DATA,  32'd0);
    tick();
    expect_val(0, F_DATA, 32'h0050_0093);
    tick();
    d_addr[0] = 32'd1;
    expect_val(0, F_DATA, 32'd0);
    tick();
    expect_val(0, F_DATA, 32'h0010_8113);

    // Word together with done; upper address bits out of range
    prog_q = '{32'h1234_5678};
    do_load(0, 1'b1);
    expect_val(0, F_CNT,   32'd1);
    expect_val(0, F_READY, 32'd1);
    d_addr[0] = 32'h0000_0400;
    expect_val(0, F_DATA, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_val(0, F_DATA, 32'd0);
    end
    tick();
    d_addr[0] = 32'd0;
    expect_val(0, F_DATA, 32'd0);
    tick();
    expect_val(0, F_DATA, 32'h1234_5678);

    // Asynchronous reset during RUN, then reload
    prog_q = '{32'hAAAA_0001, 32'hBBBB_0002};
    do_load(0, 1'b0);
    d_addr[0] = 32'd1;
    expect_val(0, F_DATA, 32'd0);
    tick();
    expect_val(0, F_DATA, 32'hBBBB_0002);
    tick();
    rst_n = 1'b0;
    expect_val(0, F_DATA,  32'd0);
    expect_val(0, F_READY, 32'd0);
    expect_val(0, F_CNT,   32'd0);
    expect_val(0, F_ERR,   32'd0);
    expect_val(0, F_STATE, 32'd0);
    tick();
    rst_n = 1'b1;
    expect_val(0, F_DATA,  32'd0);
    expect_val(0, F_READY, 32'd0);
    prog_q = '{32'h1111_0001, 32'h2222_0002};
    do_load(0, 1'b0);
    expect_val(0, F_DATA, 32'd0);
    tick();
    expect_val(0, F_DATA, 32'h2222_0002);

    // Address sweep, WAIT_CYC = 2: two bubbles per address, addr 3 unloaded
    prog_q = '{32'h0050_0093, 32'h0010_8113, 32'h0000_006F};
    do_load(1, 1'b0);
    expect_val(1, F_CNT, 32'd3);
    for (int a = 0; a < 4; a++) begin
      d_addr[1] = 32'(a);
      for (int k = 0; k < ((a == 3) ? 6 : 3); k++) begin
        expect_val(1, F_DATA, (k < 2 || a == 3) ? 32'd0 : prog_q[a]);
        tick();
      end
    end

    // Overflow on DEPTH = 4
    prog_q = '{32'h0000_A001, 32'h0000_A002, 32'h0000_A003, 32'h0000_A004, 32'h0000_A005};
    do_load(1, 1'b0);
    expect_val(1, F_CNT,   32'd4);
    expect_val(1, F_ERR,   32'd1);
    expect_val(1, F_READY, 32'd1);
    expect_val(1, F_DATA,  32'd0);
    d_valid[1] = 1'b1;
    d_data[1]  = 32'hFFFF_FFFF;
    tick();
    expect_val(1, F_CNT,  32'd4);
    expect_val(1, F_DATA, 32'd0);
    tick();
    expect_val(1, F_DATA, 32'h0000_A004);
    expect_val(1, F_ERR,  32'd1);

    // Empty load returns to EMPTY and clears the error
    prog_q.delete();
    do_load(1, 1'b0);
    expect_val(1, F_STATE, 32'd0);
    expect_val(1, F_READY, 32'd0);
    expect_val(1, F_DATA,  32'd0);
    expect_val(1, F_ERR,   32'd0);

    // WAIT_CYC = 0: same-cycle data
    prog_q = '{32'hCAFE_0001, 32'hCAFE_0002};
    do_load(2, 1'b0);
    d_addr[2] = 32'd0;
    expect_val(2, F_DATA, 32'hCAFE_0001);
    tick();
    d_addr[2] = 32'd1;
    expect_val(2, F_DATA, 32'hCAFE_0002);
    tick();
    d_addr[2] = 32'd2;
    expect_val(2, F_DATA, 32'd0);

    // Restart inside LOAD with a colliding word: start wins
    tick();
    d_start[2] = 1'b1;
    tick();
    d_valid[2] = 1'b1;
    d_data[2]  = 32'h1111_1111;
    tick();
    d_start[2] = 1'b1;
    d_valid[2] = 1'b1;
    d_data[2]  = 32'hDEAD_BEEF;
    expect_val(2, F_CNT, 32'd1);
    tick();
    d_valid[2] = 1'b1;
    d_data[2]  = 32'hBEEF_0009;
    d_done[2]  = 1'b1;
    expect_val(2, F_CNT, 32'd0);
    tick();
    expect_val(2, F_CNT,   32'd1);
    expect_val(2, F_READY, 32'd1);
    d_addr[2] = 32'd0;
    expect_val(2, F_DATA, 32'hBEEF_0009);
    d_addr[2] = 32'd0;

    tick();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
